testdrive_apb_master_arbiter: RTL and testbench
===============================================

Name: testdrive_apb_master_arbiter

Overview:
- Shares one APB master port among C_REQ_COUNT local requesters, each using a simple hold-until-done request interface.
- Round-robin arbitration; runs each granted request as a standard APB SETUP/ACCESS transfer.
- Returns read data and error status to the granted requester.
- Sits between TestDrive bus BFMs or internal engines and a single APB slave register bank.

Parameters:
- C_REQ_COUNT, 4, number of requesters; legal range 2..16.
- C_ADDR_BITS, 10, APB address width.
- C_TIME_OUT, 3000, maximum ACCESS cycles waiting for PREADY; 0 disables the limit. Only used with the optional feature.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous reset, active-high.
- REQ  input  C_REQ_COUNT  per-requester request; held high until that requester's DONE bit is seen.
- REQ_WRITE  input  C_REQ_COUNT  1 = write, 0 = read.
- REQ_ADDR  input  C_REQ_COUNT*C_ADDR_BITS  packed addresses; requester i uses slice i.
- REQ_WDATA  input  C_REQ_COUNT*32  packed write data.
- REQ_STRB  input  C_REQ_COUNT*4  packed byte strobes.
- DONE  output  C_REQ_COUNT  one-cycle completion pulse, one-hot.
- RSP_RDATA  output  32  read data, valid while DONE is nonzero.
- RSP_ERR  output  1  error flag, valid while DONE is nonzero.
- BUSY  output  1  high in any state other than IDLE.
- TIMEOUT  output  1  one-cycle pulse on a timeout abort.
- PSEL, PENABLE, PWRITE  output  1 each  APB control.
- PADDR  output  C_ADDR_BITS  APB address.
- PWDATA  output  32  APB write data.
- PSTRB  output  4  APB strobes.
- PRDATA  input  32  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high.
  - All outputs are registered.
  - On reset, every output is 0, the FSM goes to IDLE and the round-robin pointer is set to C_REQ_COUNT-1, so requester 0 wins first.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If REQ is nonzero, grant the first set bit searching from pointer+1 upward, wrapping modulo C_REQ_COUNT.
  - Latch the granted requester's write, addr, wdata and strb; set pointer to the grant; go to SETUP.
  - On that edge: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latched values.
  - PSTRB = strb for writes, 4'h0 for reads.
- SETUP: always moves to ACCESS after one cycle; PENABLE=1.
- ACCESS:
  - Hold every APB output stable.
  - On an edge where PREADY=1: capture PRDATA (reads) or 0 (writes) into RSP_RDATA and PSLVERR into RSP_ERR, pulse DONE[grant], drive PSEL=PENABLE=0, go to RESP.
- RESP:
  - One cycle with DONE high. Arbitration is suppressed, so the just-served requester can drop REQ on this edge without being re-granted.
  - Then DONE=0 and the FSM returns to IDLE.
- Latency:
  - REQ sampled in IDLE at edge t: PSEL at t+1, PENABLE at t+2.
  - With zero wait states, DONE is asserted at t+3.
  - Minimum spacing between transfers is 4 cycles.
- Requests:
  - REQ bits may rise at any time; a non-granted REQ waits with no side effects.
  - Dropping REQ before DONE is illegal and need not be handled.
- PADDR, PWDATA and PSTRB keep their last values while idle. PWRITE and PSEL return to 0.
- Reset mid-operation: the transfer is abandoned with no DONE. APB outputs are 0 on the next edge and the pointer is reset.
- RSP_RDATA and RSP_ERR hold their values until the next completion.

Optional Feature:
- Macro: TESTDRIVE_APB_ARBITER_TIMEOUT_EN.
- Defined, with C_TIME_OUT>0:
  - A cycle counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count equals C_TIME_OUT: abort with PSEL=PENABLE=0, DONE[grant] pulse, RSP_ERR=1, RSP_RDATA=0, one-cycle TIMEOUT pulse, go to RESP.
  - PREADY arriving on the same edge as expiry wins: normal completion, no TIMEOUT.
- Defined with C_TIME_OUT=0, or macro undefined: ACCESS waits indefinitely, TIMEOUT is tied to 0 and the counter logic is absent.

Test Plan:
- Write path: REQ[0]=1, write, addr 0x010, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> PSEL at t+1, PENABLE at t+2, PWDATA=0xDEADBEEF, PSTRB=0xF, DONE=4'b0001 at t+3, RSP_ERR=0.
- Read with wait states: REQ[2] read of addr 0x3FC, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> PSTRB=0, ACCESS lasts 4 cycles, DONE=4'b0100 with RSP_RDATA=0x12345678.
- Round-robin: all 4 REQ held high, each requester re-asserts after its DONE -> grant order 0,1,2,3,0,1; no requester served twice in a row while others wait.
- Slave error: PSLVERR=1 with PREADY=1 on a write from requester 1 -> DONE=4'b0010, RSP_ERR=1, BUSY low the cycle after RESP.
- Timeout: macro on, C_TIME_OUT=16, PREADY held 0 -> after 16 ACCESS cycles DONE pulse, RSP_ERR=1, TIMEOUT=1, PSEL=0. Macro off -> still in ACCESS after 100 cycles with no DONE.
- Reset mid-transfer: RST=1 for one cycle during ACCESS -> next edge PSEL=PENABLE=BUSY=0, no DONE pulse. Afterwards with REQ=4'b1111, requester 0 is granted first.

Source files
------------

// File: rtl/testdrive_apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master port among C_REQ_COUNT hold-until-done requesters.
// Optional ACCESS timeout is enabled by defining TESTDRIVE_APB_ARBITER_TIMEOUT_EN.
module testdrive_apb_master_arbiter #(
  parameter int unsigned C_REQ_COUNT = 4,
  parameter int unsigned C_ADDR_BITS = 10,
  parameter int unsigned C_TIME_OUT  = 3000
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [C_REQ_COUNT-1:0]             REQ,
  input  logic [C_REQ_COUNT-1:0]             REQ_WRITE,
  input  logic [C_REQ_COUNT*C_ADDR_BITS-1:0] REQ_ADDR,
  input  logic [C_REQ_COUNT*32-1:0]          REQ_WDATA,
  input  logic [C_REQ_COUNT*4-1:0]           REQ_STRB,
  output logic [C_REQ_COUNT-1:0]             DONE,
  output logic [31:0]                        RSP_RDATA,
  output logic                               RSP_ERR,
  output logic                               BUSY,
  output logic                               TIMEOUT,
  output logic                               PSEL,
  output logic                               PENABLE,
  output logic                               PWRITE,
  output logic [C_ADDR_BITS-1:0]             PADDR,
  output logic [31:0]                        PWDATA,
  output logic [3:0]                         PSTRB,
  input  logic [31:0]                        PRDATA,
  input  logic                               PREADY,
  input  logic                               PSLVERR
);

  localparam int unsigned C_IDX_BITS = (C_REQ_COUNT > 1) ? $clog2(C_REQ_COUNT) : 1;

  if (C_REQ_COUNT < 2 || C_REQ_COUNT > 16 || C_TIME_OUT > 32'h7FFF_FFFF) begin : g_bad_param
    $error("testdrive_apb_master_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                   r_state, w_state_next;
  logic [C_IDX_BITS-1:0]    r_ptr, w_ptr_next;
  logic                     r_psel, w_psel_next;
  logic                     r_penable, w_penable_next;
  logic                     r_pwrite, w_pwrite_next;
  logic [C_ADDR_BITS-1:0]   r_paddr, w_paddr_next;
  logic [31:0]              r_pwdata, w_pwdata_next;
  logic [3:0]               r_pstrb, w_pstrb_next;
  logic [C_REQ_COUNT-1:0]   r_done, w_done_next;
  logic [31:0]              r_rdata, w_rdata_next;
  logic                     r_err, w_err_next;
  logic                     r_busy, w_busy_next;

  logic                     w_hit_hi, w_hit_lo, w_hit;
  logic [C_IDX_BITS-1:0]    w_idx_hi, w_idx_lo, w_grant;
  logic                     w_sel_write;
  logic [C_ADDR_BITS-1:0]   w_sel_addr;
  logic [31:0]              w_sel_wdata;
  logic [3:0]               w_sel_strb;
  logic [C_REQ_COUNT-1:0]   w_grant_onehot;

`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
  localparam int unsigned C_CNT_BITS = (C_TIME_OUT > 0) ? $clog2(C_TIME_OUT + 1) : 1;
  logic [C_CNT_BITS-1:0]    r_cnt, w_cnt_next, w_cnt_inc;
  logic                     r_timeout, w_timeout_next;
`endif

  // Descending scan so the lowest index wins; indices above the pointer take precedence.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int i = C_REQ_COUNT - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        if (C_IDX_BITS'(i) > r_ptr) begin
          w_hit_hi = 1'b1;
          w_idx_hi = C_IDX_BITS'(i);
        end else begin
          w_hit_lo = 1'b1;
          w_idx_lo = C_IDX_BITS'(i);
        end
      end
    end
    w_hit   = w_hit_hi | w_hit_lo;
    w_grant = w_hit_hi ? w_idx_hi : w_idx_lo;
  end

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_strb  = '0;
    for (int i = 0; i < C_REQ_COUNT; i++) begin
      if (C_IDX_BITS'(i) == w_grant) begin
        w_sel_write = REQ_WRITE[i];
        w_sel_addr  = REQ_ADDR[i*C_ADDR_BITS +: C_ADDR_BITS];
        w_sel_wdata = REQ_WDATA[i*32 +: 32];
        w_sel_strb  = REQ_STRB[i*4 +: 4];
      end
    end
  end

  assign w_grant_onehot = {{(C_REQ_COUNT-1){1'b0}}, 1'b1} << r_ptr;

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_psel_next    = r_psel;
    w_penable_next = r_penable;
    w_pwrite_next  = r_pwrite;
    w_paddr_next   = r_paddr;
    w_pwdata_next  = r_pwdata;
    w_pstrb_next   = r_pstrb;
    w_done_next    = '0;
    w_rdata_next   = r_rdata;
    w_err_next     = r_err;
`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
    w_cnt_inc      = r_cnt + 1'b1;
    w_cnt_next     = r_cnt;
    w_timeout_next = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_hit) begin
          w_state_next   = StSetup;
          w_ptr_next     = w_grant;
          w_psel_next    = 1'b1;
          w_penable_next = 1'b0;
          w_pwrite_next  = w_sel_write;
          w_paddr_next   = w_sel_addr;
          w_pwdata_next  = w_sel_wdata;
          w_pstrb_next   = w_sel_write ? w_sel_strb : 4'h0;
        end
      end
      StSetup: begin
        w_state_next   = StAccess;
        w_penable_next = 1'b1;
`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
        w_cnt_next     = '0;
`endif
      end
      StAccess: begin
        if (PREADY) begin
          w_state_next   = StResp;
          w_rdata_next   = r_pwrite ? 32'h0 : PRDATA;
          w_err_next     = PSLVERR;
          w_done_next    = w_grant_onehot;
          w_psel_next    = 1'b0;
          w_penable_next = 1'b0;
          w_pwrite_next  = 1'b0;
        end
`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
        else if ((C_TIME_OUT > 0) && (w_cnt_inc == C_CNT_BITS'(C_TIME_OUT))) begin
          w_state_next   = StResp;
          w_rdata_next   = 32'h0;
          w_err_next     = 1'b1;
          w_done_next    = w_grant_onehot;
          w_timeout_next = 1'b1;
          w_psel_next    = 1'b0;
          w_penable_next = 1'b0;
          w_pwrite_next  = 1'b0;
        end else if (C_TIME_OUT > 0) begin
          w_cnt_next = w_cnt_inc;
        end
`endif
      end
      StResp: begin
        // No arbitration here: the served requester drops REQ on this edge.
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    w_busy_next = (w_state_next != StIdle);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_ptr     <= C_IDX_BITS'(C_REQ_COUNT - 1);
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_psel    <= w_psel_next;
      r_penable <= w_penable_next;
      r_pwrite  <= w_pwrite_next;
      r_paddr   <= w_paddr_next;
      r_pwdata  <= w_pwdata_next;
      r_pstrb   <= w_pstrb_next;
      r_done    <= w_done_next;
      r_rdata   <= w_rdata_next;
      r_err     <= w_err_next;
      r_busy    <= w_busy_next;
`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
`endif
    end
  end

  assign DONE      = r_done;
  assign RSP_RDATA = r_rdata;
  assign RSP_ERR   = r_err;
  assign BUSY      = r_busy;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
  assign TIMEOUT   = r_timeout;
`else
  assign TIMEOUT   = 1'b0;
`endif

endmodule

// File: tb/tb_testdrive_apb_master_arbiter.sv
// Self-checking bench for testdrive_apb_master_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin reference model.
module tb_testdrive_apb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  REQ, REQ_WRITE;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*32-1:0] REQ_WDATA;
  logic [N*4-1:0]  REQ_STRB;
  logic [N-1:0]  DONE;
  logic [31:0]   RSP_RDATA;
  logic          RSP_ERR, BUSY, TIMEOUT, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [31:0]   PRDATA;
  logic          PREADY, PSLVERR;

  testdrive_apb_master_arbiter #(
    .C_REQ_COUNT (N),
    .C_ADDR_BITS (AW),
    .C_TIME_OUT  (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .REQ_WRITE (REQ_WRITE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .REQ_STRB  (REQ_STRB),
    .DONE      (DONE),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .BUSY      (BUSY),
    .TIMEOUT   (TIMEOUT),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-requester request state and the last-served index.
  logic          req_m   [N];
  logic          wr_m    [N];
  logic [AW-1:0] addr_m  [N];
  logic [31:0]   wdata_m [N];
  logic [3:0]    strb_m  [N];
  int            ptr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      REQ[i]              = req_m[i];
      REQ_WRITE[i]        = wr_m[i];
      REQ_ADDR[i*AW +: AW] = addr_m[i];
      REQ_WDATA[i*32 +: 32] = wdata_m[i];
      REQ_STRB[i*4 +: 4]  = strb_m[i];
    end
  endtask

  task automatic rand_fields(input int i);
    wr_m[i]    = 1'($urandom_range(0, 1));
    addr_m[i]  = AW'($urandom);
    wdata_m[i] = $urandom;
    strb_m[i]  = 4'($urandom);
  endtask

  function automatic int pick(input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (req_m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // Runs one complete transfer from IDLE; caller guarantees at least one request is pending.
  task automatic run_xfer(input int waits, input logic [31:0] prd, input logic err,
                          output logic [N-1:0] done_obs);
    int g;
    logic [3:0] exp_strb;
    logic [31:0] exp_rd;
    g        = pick(ptr_m);
    ptr_m    = g;
    exp_strb = wr_m[g] ? strb_m[g] : 4'h0;
    exp_rd   = wr_m[g] ? 32'h0 : prd;
    drive();
    PREADY = 1'b0;
    @(negedge CLK);
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, addr_m[g]);
    chk("setup_pwrite", PWRITE, wr_m[g]);
    chk("setup_pwdata", PWDATA, wdata_m[g]);
    chk("setup_pstrb", PSTRB, exp_strb);
    chk("setup_busy", BUSY, 1);
    chk("setup_done", DONE, 0);
    @(negedge CLK);
    chk("access_psel", PSEL, 1);
    chk("access_penable", PENABLE, 1);
    for (int w = 0; w < waits; w++) begin
      @(negedge CLK);
      chk("wait_penable", PENABLE, 1);
      chk("wait_done", DONE, 0);
    end
    PREADY  = 1'b1;
    PRDATA  = prd;
    PSLVERR = err;
    @(negedge CLK);
    done_obs = DONE;
    chk("resp_done", DONE, 32'(1 << g));
    chk("resp_rdata", RSP_RDATA, exp_rd);
    chk("resp_err", RSP_ERR, err);
    chk("resp_psel", PSEL, 0);
    chk("resp_penable", PENABLE, 0);
    chk("resp_busy", BUSY, 1);
    chk("resp_timeout", TIMEOUT, 0);
    req_m[g] = 1'b0;
    drive();
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = $urandom;
    @(negedge CLK);
    chk("idle_done", DONE, 0);
    chk("idle_busy", BUSY, 0);
    chk("idle_psel", PSEL, 0);
    chk("idle_pwrite", PWRITE, 0);
    chk("idle_paddr_hold", PADDR, addr_m[g]);
    chk("idle_pstrb_hold", PSTRB, exp_strb);
    chk("idle_rdata_hold", RSP_RDATA, exp_rd);
  endtask

  logic [N-1:0] d;
  int           n;

  initial begin
    RST = 1'b1;
    REQ = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_STRB = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_m[i] = 1'b0;
      rand_fields(i);
    end
    ptr_m = N - 1;
    repeat (2) @(negedge CLK);
    chk("rst_outputs", {DONE, RSP_RDATA, RSP_ERR, BUSY, TIMEOUT, PSEL, PENABLE, PWRITE}, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb", PSTRB, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Write path from requester 0.
    req_m[0] = 1'b1; wr_m[0] = 1'b1; addr_m[0] = 10'h010; wdata_m[0] = 32'hDEADBEEF;
    strb_m[0] = 4'hF;
    run_xfer(0, 32'h0, 1'b0, d);
    chk("write_done", d, 4'b0001);

    // Read with three wait states from requester 2.
    req_m[2] = 1'b1; wr_m[2] = 1'b0; addr_m[2] = 10'h3FC;
    run_xfer(3, 32'h12345678, 1'b0, d);
    chk("read_done", d, 4'b0100);
    chk("read_rdata", RSP_RDATA, 32'h12345678);

    // Round-robin with all requesters continuously re-asserting; start from a fresh reset.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    ptr_m = N - 1;
    for (int i = 0; i < N; i++) begin
      req_m[i] = 1'b1;
      rand_fields(i);
    end
    for (int i = 0; i < 6; i++) begin
      run_xfer(i % 2, $urandom, 1'b0, d);
      chk("rr_order", d, 32'(1 << (i % 4)));
      req_m[(i % 4)] = 1'b1;
    end
    for (int i = 0; i < N; i++) req_m[i] = 1'b0;
    drive();
    @(negedge CLK);

    // Slave error on a write from requester 1.
    req_m[1] = 1'b1; rand_fields(1); wr_m[1] = 1'b1;
    run_xfer(0, 32'h0, 1'b1, d);
    chk("slverr_done", d, 4'b0010);

    // Slave never ready: abort under the timeout build, indefinite wait otherwise.
    req_m[3] = 1'b1; rand_fields(3);
    ptr_m = pick(ptr_m);
    drive();
    PREADY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("stall_penable", PENABLE, 1);
`ifdef TESTDRIVE_APB_ARBITER_TIMEOUT_EN
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (DONE != '0) break;
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_done", DONE, 4'b1000);
    chk("to_flag", TIMEOUT, 1);
    chk("to_err", RSP_ERR, 1);
    chk("to_rdata", RSP_RDATA, 0);
    chk("to_psel", PSEL, 0);
    chk("to_penable", PENABLE, 0);
    req_m[3] = 1'b0;
    drive();
    @(negedge CLK);
    chk("to_flag_pulse", TIMEOUT, 0);
    chk("to_busy", BUSY, 0);
`else
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (DONE == '0 && PENABLE && PSEL && !TIMEOUT) n++;
    end
    chk("stall_cycles", n, 100);
    PREADY = 1'b1; PRDATA = 32'hA5A5_0003; PSLVERR = 1'b0;
    @(negedge CLK);
    chk("stall_done", DONE, 4'b1000);
    req_m[3] = 1'b0;
    drive();
    PREADY = 1'b0;
    @(negedge CLK);
    chk("stall_busy", BUSY, 0);
`endif

    // Reset during ACCESS abandons the transfer and restores the pointer.
    req_m[2] = 1'b1; rand_fields(2);
    drive();
    repeat (3) @(negedge CLK);
    chk("mid_penable", PENABLE, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_paddr", PADDR, 0);
    RST = 1'b0;
    ptr_m = N - 1;
    for (int i = 0; i < N; i++) begin
      req_m[i] = 1'b1;
      rand_fields(i);
    end
    run_xfer(0, $urandom, 1'b0, d);
    chk("post_rst_first", d, 4'b0001);

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_m[i] && $urandom_range(0, 1) == 1) begin
          req_m[i] = 1'b1;
          rand_fields(i);
        end
      end
      if (!(req_m[0] | req_m[1] | req_m[2] | req_m[3])) begin
        n = $urandom_range(0, N - 1);
        req_m[n] = 1'b1;
        rand_fields(n);
      end
      run_xfer($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)), d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
